palette_engine: RTL and testbench
=================================

PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, palette index width; ENTRIES = 2**INDEX_W.
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter FADE_DIV, default 2, number of frame_start pulses per fade step (>=1).
REQ-004 SHALL have parameter DEFAULT_PAL, default all-zero, ENTRIES*3*CH_W bits; entry i occupies bits [(i+1)*3*CH_W-1 : i*3*CH_W] as {R,G,B}.
REQ-005 SHALL have port Clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rd_valid, input, 1, lookup request qualifier.
REQ-008 SHALL have port rd_index, input, INDEX_W, lookup index.
REQ-009 SHALL have port wr_en, input, 1, palette entry write strobe.
REQ-010 SHALL have port wr_index, input, INDEX_W, entry to write.
REQ-011 SHALL have port wr_rgb, input, 3*CH_W, {R,G,B} write data.
REQ-012 SHALL have port fade_cmd, input, 2, fade command: 00 hold, 01 fade out, 10 fade in, 11 snap to full.
REQ-013 SHALL have port frame_start, input, 1, one-cycle pulse per video frame.
REQ-014 SHALL have port red, green, blue, output, CH_W each, scaled colour.
REQ-015 SHALL have port out_valid, output, 1, marks red/green/blue valid.
REQ-016 SHALL have port fade_busy, output, 1, high while fade state is FADE_OUT or FADE_IN.
REQ-017 SHALL have port level, output, CH_W+1, current brightness, 0 to 2**CH_W.

Function
REQ-018 SHALL store ENTRIES x 3*CH_W palette registers, writable at runtime.
REQ-019 SHALL write wr_rgb into entry wr_index on a rising edge with wr_en=1; no handshake, always accepted.
REQ-020 SHALL have two-cycle lookup latency: stage 1 registers entry[rd_index] and rd_valid; stage 2 registers scaled channels and out_valid.
REQ-021 SHALL accept one request per cycle (fully pipelined); out_valid at cycle N+2 equals rd_valid at cycle N.
REQ-022 SHALL return pre-write data when a read and a write hit the same index in the same cycle; a read one cycle later returns new data.
REQ-023 SHALL hold red/green/blue at their last values when out_valid=0.
REQ-024 SHALL compute each channel as (c * level) >> CH_W with a 2*CH_W+1-bit intermediate; level=2**CH_W passes c unchanged, level=0 yields 0.
REQ-025 SHALL use level from the cycle in which stage 2 captures, not the cycle the request was issued.
REQ-026 SHALL implement fade FSM states IDLE, FADE_OUT, FADE_IN.
REQ-027 SHALL, in IDLE: fade_cmd=01 -> FADE_OUT; 10 -> FADE_IN; 11 -> level=2**CH_W, stay IDLE; 00 -> stay.
REQ-028 SHALL keep a divide counter 0..FADE_DIV-1 that advances only on frame_start in FADE states; on wrap, level -/+ 1.
REQ-029 SHALL, in FADE_OUT, return to IDLE on the step that makes level 0; in FADE_IN, on the step that makes level 2**CH_W.
REQ-030 SHALL clamp level: never below 0 or above 2**CH_W; a fade toward a level already reached returns to IDLE next cycle with no change.
REQ-031 SHALL, on fade_cmd 01/10 during a fade, reverse direction immediately without clearing the divide counter; 11 aborts to IDLE with level=2**CH_W; 00 continues.
REQ-032 SHALL clear the divide counter on every entry to IDLE.

Reset
REQ-033 SHALL, on Reset_n=0, asynchronously load all entries from DEFAULT_PAL, set FSM=IDLE, divide counter 0, level=2**CH_W, clear pipeline valids, red/green/blue=0, out_valid=0, fade_busy=0.
REQ-034 SHALL discard in-flight lookups and fades on reset mid-operation; the first valid output after release requires a new request.

Verification
REQ-035 SHALL cover: reset with DEFAULT_PAL entry0=0x2AF, entry15=0xFFF; rd_index 0 then 15 on consecutive cycles -> outputs 0x2AF then 0xFFF, out_valid 2 cycles after each request.
REQ-036 SHALL cover: wr_en, wr_index=3, wr_rgb=0x741 with same-cycle read of 3 -> old value; read next cycle -> 0x741.
REQ-037 SHALL cover: FADE_DIV=2, fade_cmd=01, 16 frame_start pulses -> level 8; read 0x2AF -> 0x157; 16 more pulses -> level 0, fade_busy falls, outputs 0x000.
REQ-038 SHALL cover: fade_cmd=10 from level 0 after 32 pulses -> level 16, IDLE; fade_cmd=10 again -> no change, IDLE after 1 cycle.
REQ-039 SHALL cover: fade_cmd=11 mid FADE_OUT at level 5 -> level 16, fade_busy=0 next cycle.
REQ-040 SHALL cover: Reset_n asserted mid-fade with a read in flight -> level 16, out_valid=0, no stale output after release.

Source files
------------

// File: rtl/palette_engine.sv
// ----------------------------------------------------------------------------
// palette_engine
//   Runtime-writable colour palette with a two-stage lookup pipeline and a
//   frame-paced brightness fader. Every lookup result is scaled by the
//   brightness level that is current when the result is registered.
//
//   Ports
//     Clk          sole clock, rising edge
//     Reset_n      asynchronous active-low reset
//     rd_valid     lookup request qualifier (one request per cycle)
//     rd_index     palette entry to look up
//     wr_en        palette write strobe (always accepted)
//     wr_index     palette entry to write
//     wr_rgb       {R,G,B} write data
//     fade_cmd     00 hold, 01 fade out, 10 fade in, 11 snap to full
//     frame_start  one-cycle pulse per video frame
//     red/green/blue  scaled colour, held while out_valid is low
//     out_valid    red/green/blue carry a new result (rd_valid delayed 2)
//     fade_busy    fader is stepping (FADE_OUT or FADE_IN)
//     level        brightness, 0 .. 2**CH_W
// ----------------------------------------------------------------------------

// One colour channel: (c * level) >> CH_W. The level is one bit wider than
// the channel so that full brightness passes c through unchanged.
module palette_scale #(
   parameter int CH_W = 4
) (
   input  logic [CH_W-1:0] c,
   input  logic [CH_W:0]   level,
   output logic [CH_W-1:0] s
);
   logic [2*CH_W:0] prod;
   logic            unused_prod_hi;

   assign prod = {{(CH_W+1){1'b0}}, c} * {{CH_W{1'b0}}, level};
   // The product never exceeds c << CH_W, so the top bit is always zero.
   assign s              = prod[2*CH_W-1:CH_W];
   assign unused_prod_hi = prod[2*CH_W];
endmodule

module palette_engine #(
   parameter int INDEX_W  = 4,
   parameter int CH_W     = 4,
   parameter int FADE_DIV = 2,
   parameter logic [(2**INDEX_W)*3*CH_W-1:0] DEFAULT_PAL = '0
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               rd_valid,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [3*CH_W-1:0]  wr_rgb,
   input  logic [1:0]         fade_cmd,
   input  logic               frame_start,
   output logic [CH_W-1:0]    red,
   output logic [CH_W-1:0]    green,
   output logic [CH_W-1:0]    blue,
   output logic               out_valid,
   output logic               fade_busy,
   output logic [CH_W:0]      level
);
   localparam int ENTRIES  = 2**INDEX_W;
   localparam int STAGES   = 2;
   localparam int NUM_CH   = 3;
   localparam int DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
   localparam logic [CH_W:0]    LVL_MAX  = {1'b1, {CH_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      FADE_IN  = 2'd2
   } fade_state_e;

   // Channel index 2 is R (most significant), 0 is B.
   logic [ENTRIES-1:0][NUM_CH-1:0][CH_W-1:0] pal;
   logic [NUM_CH-1:0][CH_W-1:0]              s1_rgb;
   logic [NUM_CH-1:0][CH_W-1:0]              scaled;
   logic [NUM_CH-1:0][CH_W-1:0]              rgb_q;
   logic [STAGES:1]                          vld_pipe;

   fade_state_e      state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CH_W:0]    level_q, level_d;
   fade_state_e      dir;
   logic             at_target;
   logic [CH_W:0]    step_lvl;

   // ---------------------------------------------------------------- palette
   // Stage 1 reads the register file on the same edge a write lands, so a
   // same-cycle read of the written entry sees the old contents.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pal <= DEFAULT_PAL;
      end else if (wr_en) begin
         pal[wr_index] <= wr_rgb;
      end
   end

   // ---------------------------------------------------------------- lookup
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vld_pipe <= '0;
         s1_rgb   <= '0;
         rgb_q    <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], rd_valid};
         s1_rgb   <= pal[rd_index];
         // Outputs hold their last result between valid beats.
         if (vld_pipe[1]) rgb_q <= scaled;
      end
   end

   // Scaling uses the live level, i.e. the level when stage 2 captures.
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      palette_scale #(.CH_W(CH_W)) u_scale (
         .c     (s1_rgb[ch]),
         .level (level_q),
         .s     (scaled[ch])
      );
   end

   assign red       = rgb_q[2];
   assign green     = rgb_q[1];
   assign blue      = rgb_q[0];
   assign out_valid = vld_pipe[STAGES];

   // ---------------------------------------------------------------- fader
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         level_q <= LVL_MAX;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         level_q <= level_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      level_d   = level_q;
      dir       = state_q;
      at_target = 1'b0;
      step_lvl  = level_q;
      unique case (state_q)
         IDLE: begin
            div_d = '0;
            unique case (fade_cmd)
               2'b01:   state_d = FADE_OUT;
               2'b10:   state_d = FADE_IN;
               2'b11:   level_d = LVL_MAX;
               default: ;
            endcase
         end
         FADE_OUT, FADE_IN: begin
            if (fade_cmd == 2'b11) begin
               state_d = IDLE;
               div_d   = '0;
               level_d = LVL_MAX;
            end else begin
               // A reversal takes effect this cycle; the divide count carries
               // over so the partial frame interval is not lost.
               if (fade_cmd == 2'b01) dir = FADE_OUT;
               if (fade_cmd == 2'b10) dir = FADE_IN;
               state_d   = dir;
               at_target = (dir == FADE_OUT) ? (level_q == '0)
                                             : (level_q == LVL_MAX);
               step_lvl  = (dir == FADE_OUT) ? level_q - 1'b1
                                             : level_q + 1'b1;
               if (at_target) begin
                  // Already at the end point: finish without touching level.
                  state_d = IDLE;
                  div_d   = '0;
               end else if (frame_start) begin
                  if (div_q == DIV_LAST) begin
                     div_d   = '0;
                     level_d = step_lvl;
                     if ((dir == FADE_OUT && step_lvl == '0) ||
                         (dir == FADE_IN  && step_lvl == LVL_MAX))
                        state_d = IDLE;
                  end else begin
                     div_d = div_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            div_d   = '0;
         end
      endcase
   end

   assign fade_busy = (state_q == FADE_OUT) || (state_q == FADE_IN);
   assign level     = level_q;
endmodule

// File: tb/tb_palette_engine.sv
// ----------------------------------------------------------------------------
// tb_palette_engine
//   Directed stimulus for palette_engine with literal expectations at each
//   scenario, plus a cycle-by-cycle compare against a behavioural model of
//   the palette, the lookup timing and the fader.
// ----------------------------------------------------------------------------
module tb_palette_engine;
   localparam int IW = 4;
   localparam int CW = 4;
   localparam int FD = 2;
   // entry0 = 0x2AF, entry3 = 0x123, entry15 = 0xFFF, others 0
   localparam logic [191:0] PAL = {12'hFFF, {11{12'h000}}, 12'h123,
                                   12'h000, 12'h000, 12'h2AF};

   logic          Clk = 1'b0, Reset_n = 1'b0;
   logic          rd_valid = 1'b0, wr_en = 1'b0, frame_start = 1'b0;
   logic [IW-1:0] rd_index = '0, wr_index = '0;
   logic [11:0]   wr_rgb = '0;
   logic [1:0]    fade_cmd = '0;
   logic [CW-1:0] red, green, blue;
   logic          out_valid, fade_busy;
   logic [CW:0]   level;

   palette_engine #(.INDEX_W(IW), .CH_W(CW), .FADE_DIV(FD),
                    .DEFAULT_PAL(PAL)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .rd_valid(rd_valid), .rd_index(rd_index),
      .wr_en(wr_en), .wr_index(wr_index), .wr_rgb(wr_rgb),
      .fade_cmd(fade_cmd), .frame_start(frame_start), .red(red),
      .green(green), .blue(blue), .out_valid(out_valid),
      .fade_busy(fade_busy), .level(level));

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   int m_pal [16];
   int m_lvl, m_mode, m_div, m_rgb, m_ov;  // m_mode: 0 idle, 1 out, 2 in
   int m_q [$];                            // rgb of last request, -1 = none

   function automatic int scale(int rgb, int lvl);
      int r, g, b;
      r = (((rgb >> 8) & 15) * lvl) >> 4;
      g = (((rgb >> 4) & 15) * lvl) >> 4;
      b = ((rgb & 15) * lvl) >> 4;
      return (r << 8) | (g << 4) | b;
   endfunction

   always @(posedge Clk) begin
      int x, tgt;
      if (!Reset_n) begin
         for (int i = 0; i < 16; i++) m_pal[i] = int'(PAL[i*12 +: 12]);
         m_lvl = 16; m_mode = 0; m_div = 0; m_rgb = 0; m_ov = 0;
         m_q.delete();
      end else begin
         // result of the request issued one edge ago, at today's level
         x = (m_q.size() > 0) ? m_q.pop_front() : -1;
         m_ov = (x >= 0);
         if (x >= 0) m_rgb = scale(x, m_lvl);
         m_q.push_back(rd_valid ? m_pal[rd_index] : -1);
         if (wr_en) m_pal[wr_index] = int'(wr_rgb);
         if (m_mode == 0) begin
            if (fade_cmd == 2'b01) m_mode = 1;
            else if (fade_cmd == 2'b10) m_mode = 2;
            else if (fade_cmd == 2'b11) m_lvl = 16;
         end else if (fade_cmd == 2'b11) begin
            m_mode = 0; m_div = 0; m_lvl = 16;
         end else begin
            if (fade_cmd == 2'b01) m_mode = 1;
            else if (fade_cmd == 2'b10) m_mode = 2;
            tgt = (m_mode == 1) ? 0 : 16;
            if (m_lvl == tgt) begin
               m_mode = 0; m_div = 0;
            end else if (frame_start) begin
               m_div++;
               if (m_div == FD) begin
                  m_div = 0;
                  m_lvl += (m_mode == 1) ? -1 : 1;
                  if (m_lvl == tgt) m_mode = 0;
               end
            end
         end
      end
      #1;
      chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
      chk("cmp_level", 32'(level), 32'(m_lvl));
      chk("cmp_fade_busy", 32'(fade_busy), 32'(m_mode != 0));
      chk("cmp_rgb", 32'({red, green, blue}), 32'(m_rgb));
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic pulse();
      frame_start = 1'b1; tick();
      frame_start = 1'b0; tick();
   endtask

   task automatic lookup(input int idx);
      rd_valid = 1'b1; rd_index = 4'(idx); tick();
      rd_valid = 1'b0; tick();
   endtask

   task automatic cmd(input logic [1:0] c);
      fade_cmd = c; tick();
      fade_cmd = 2'b00;
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_level", 32'(level), 16);
      chk("reset_busy", 32'(fade_busy), 0);
      chk("reset_rgb", 32'({red, green, blue}), 0);
      Reset_n = 1'b1; tick();

      // back-to-back lookups of entries 0 and 15
      rd_valid = 1'b1; rd_index = 4'd0; tick();
      rd_index = 4'd15; tick();
      chk("lut0_rgb", 32'({red, green, blue}), 32'h2AF);
      chk("lut0_valid", 32'(out_valid), 1);
      rd_valid = 1'b0; tick();
      chk("lut15_rgb", 32'({red, green, blue}), 32'hFFF);
      tick();
      chk("hold_valid", 32'(out_valid), 0);
      chk("hold_rgb", 32'({red, green, blue}), 32'hFFF);

      // write and read of the same entry in one cycle
      wr_en = 1'b1; wr_index = 4'd3; wr_rgb = 12'h741;
      rd_valid = 1'b1; rd_index = 4'd3; tick();
      wr_en = 1'b0; tick();
      chk("rw_same_cycle_old", 32'({red, green, blue}), 32'h123);
      rd_valid = 1'b0; tick();
      chk("rw_next_cycle_new", 32'({red, green, blue}), 32'h741);

      // fade out half way, then to black
      cmd(2'b01);
      chk("fade_out_busy", 32'(fade_busy), 1);
      repeat (16) pulse();
      chk("fade_half_level", 32'(level), 8);
      chk("fade_half_busy", 32'(fade_busy), 1);
      lookup(0);
      chk("fade_half_rgb", 32'({red, green, blue}), 32'h157);
      repeat (16) pulse();
      chk("fade_black_level", 32'(level), 0);
      chk("fade_black_busy", 32'(fade_busy), 0);
      lookup(0);
      chk("fade_black_rgb", 32'({red, green, blue}), 32'h000);

      // fade in to full, then a redundant fade in
      cmd(2'b10);
      repeat (32) pulse();
      chk("fade_in_level", 32'(level), 16);
      chk("fade_in_busy", 32'(fade_busy), 0);
      cmd(2'b10);
      chk("redundant_busy", 32'(fade_busy), 1);
      chk("redundant_level", 32'(level), 16);
      tick();
      chk("redundant_idle", 32'(fade_busy), 0);
      chk("redundant_level2", 32'(level), 16);

      // reversal keeps the partial divide count
      cmd(2'b01);
      repeat (3) pulse();
      chk("rev_level", 32'(level), 15);
      cmd(2'b10);
      chk("rev_busy", 32'(fade_busy), 1);
      pulse();
      chk("rev_done_level", 32'(level), 16);
      chk("rev_done_busy", 32'(fade_busy), 0);

      // snap to full mid fade-out
      cmd(2'b01);
      repeat (22) pulse();
      chk("snap_pre_level", 32'(level), 5);
      cmd(2'b11);
      chk("snap_level", 32'(level), 16);
      chk("snap_busy", 32'(fade_busy), 0);

      // reset mid-fade with a lookup in flight
      cmd(2'b01);
      repeat (4) pulse();
      chk("rst_pre_level", 32'(level), 14);
      rd_valid = 1'b1; rd_index = 4'd15; tick();
      rd_valid = 1'b0; Reset_n = 1'b0; #1;
      chk("rst_level", 32'(level), 16);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(fade_busy), 0);
      tick(); tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_no_stale", 32'(out_valid), 0);
      end
      lookup(3);
      chk("rst_pal_restored", 32'({red, green, blue}), 32'h123);
      lookup(15);
      chk("rst_new_lookup", 32'({red, green, blue}), 32'hFFF);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
